hazard_stall_ctrl: RTL

- Pipeline sequencing controller for the 5-stage MIPS core; generates per-stage hold, flush and bubble controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Detects load-use hazards, tracks the multi-cycle mult/div unit that owns HI/LO, freezes the whole pipeline while data memory is waiting, and squashes the wrong-path fetch on taken branches/jumps.
- Keeps a stall-cycle performance counter and a registered stall-cause status.

---
 rtl/hazard_stall_ctrl_pkg.sv | 18 +
 rtl/hazard_stall_ctrl_muldiv_tracker.sv | 27 ++
 rtl/hazard_stall_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / stall controller.
package hazard_stall_ctrl_pkg;

  // Registered stall-cause codes reported on stall_cause.
  typedef enum logic [1:0] {
    STALL_RUN      = 2'd0,
    STALL_LOAD_USE = 2'd1,
    STALL_MULDIV   = 2'd2,
    STALL_FREEZE   = 2'd3
  } stall_cause_e;

  // Default busy time of the mult/div unit after issue.
  localparam int MULDIV_LAT_DEF = 4;

  // Width of the mult/div busy counter; covers latencies 1..15.
  localparam int MD_CNT_W = 4;

endpackage

// File: rtl/hazard_stall_ctrl_muldiv_tracker.sv
// Tracks how long the mult/div unit still owns HI/LO after an issue.
module hazard_stall_ctrl_muldiv_tracker
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int LAT = MULDIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic busy
);

  logic [MD_CNT_W-1:0] md_cnt;

  // Load latency on issue, otherwise count down to zero (also during freeze).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      md_cnt <= '0;
    else if (issue)
      md_cnt <= MD_CNT_W'(LAT);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - MD_CNT_W'(1);
  end

  assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use, mult/div and memory-freeze
// stalls, branch wrong-path squash, stall-cause status and stall counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr_1_ID,
  input  logic [REG_ADDR_W-1:0] raddr_2_ID,
  input  logic                  use_rs_ID,
  input  logic                  use_rt_ID,
  input  logic                  ReadMem_EX,
  input  logic [REG_ADDR_W-1:0] wdest_EX,
  input  logic                  muldiv_ID,
  input  logic                  mfhi_lo_ID,
  input  logic                  branch_taken_ID,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  hold_PC,
  output logic                  hold_IF_ID,
  output logic                  hold_ID_EX,
  output logic                  hold_EX_MEM,
  output logic                  hold_MEM_WB,
  output logic                  flush_IF_ID,
  output logic                  bubble_ID_EX,
  output logic                  muldiv_busy,
  output logic [1:0]            stall_cause,
  output logic [CNT_W-1:0]      stall_cycles
);

  logic freeze, lu, md, idstall, issue;
  stall_cause_e cause_nxt;

  assign freeze  = mem_req & ~mem_ready;
  assign lu      = ReadMem_EX & (wdest_EX != '0) &
                   ((use_rs_ID & (raddr_1_ID == wdest_EX)) |
                    (use_rt_ID & (raddr_2_ID == wdest_EX)));
  assign md      = muldiv_busy & (mfhi_lo_ID | muldiv_ID);
  assign idstall = ~freeze & (lu | md);
  // A busy unit makes md true, so a new op only issues once the count hits 0.
  assign issue   = muldiv_ID & ~freeze & ~idstall;

  hazard_stall_ctrl_muldiv_tracker #(.LAT(MULDIV_LAT)) u_md (
    .clk   (clk),
    .rst   (rst),
    .issue (issue),
    .busy  (muldiv_busy)
  );

  // Per-stage controls: freeze beats ID stall beats branch squash; all quiet in reset.
  always_comb begin
    hold_PC      = 1'b0;
    hold_IF_ID   = 1'b0;
    hold_ID_EX   = 1'b0;
    hold_EX_MEM  = 1'b0;
    hold_MEM_WB  = 1'b0;
    flush_IF_ID  = 1'b0;
    bubble_ID_EX = 1'b0;
    cause_nxt    = STALL_RUN;
    if (freeze) begin
      hold_PC     = 1'b1;
      hold_IF_ID  = 1'b1;
      hold_ID_EX  = 1'b1;
      hold_EX_MEM = 1'b1;
      hold_MEM_WB = 1'b1;
      cause_nxt   = STALL_FREEZE;
    end else if (idstall) begin
      hold_PC      = 1'b1;
      hold_IF_ID   = 1'b1;
      bubble_ID_EX = 1'b1;
      cause_nxt    = lu ? STALL_LOAD_USE : STALL_MULDIV;
    end else begin
      flush_IF_ID = branch_taken_ID;
    end
    if (rst) begin
      hold_PC      = 1'b0;
      hold_IF_ID   = 1'b0;
      hold_ID_EX   = 1'b0;
      hold_EX_MEM  = 1'b0;
      hold_MEM_WB  = 1'b0;
      flush_IF_ID  = 1'b0;
      bubble_ID_EX = 1'b0;
    end
  end

  // Registered stall cause and wrapping count of PC-hold cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cause  <= STALL_RUN;
      stall_cycles <= '0;
    end else begin
      stall_cause <= cause_nxt;
      if (hold_PC)
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
